alu_cmd_master: RTL and testbench

//  Host-side initiator for the UART ALU link: sends one 3-byte command frame (A, B, OPCODE) through the

---
 rtl/uart_alu_pkg.sv | 28 ++
 rtl/timeout_counter.sv | 32 +++
 rtl/alu_cmd_master.sv | 155 +++++++++++++++
 tb/tb_alu_cmd_master.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU link: master FSM states, frame
// geometry and the opcode set understood by the ALU-side command decoder.
package uart_alu_pkg;

   localparam int DEFAULT_BUS_SIZE = 8;
   localparam int OPCODE_W         = DEFAULT_BUS_SIZE - 2;
   localparam int FRAME_LEN        = 3;   // A, B, OPCODE

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FLUSH    = 3'd1,
      ST_SEND_A   = 3'd2,
      ST_SEND_B   = 3'd3,
      ST_SEND_OP  = 3'd4,
      ST_WAIT_RES = 3'd5
   } state_t;

   // Opcodes shared with the ALU-side decoder.
   localparam logic [OPCODE_W-1:0] OP_ADD = 6'h20;
   localparam logic [OPCODE_W-1:0] OP_SUB = 6'h22;
   localparam logic [OPCODE_W-1:0] OP_AND = 6'h24;
   localparam logic [OPCODE_W-1:0] OP_OR  = 6'h25;
   localparam logic [OPCODE_W-1:0] OP_XOR = 6'h26;
   localparam logic [OPCODE_W-1:0] OP_NOR = 6'h27;
   localparam logic [OPCODE_W-1:0] OP_SRA = 6'h03;
   localparam logic [OPCODE_W-1:0] OP_SRL = 6'h02;

endpackage

// File: rtl/timeout_counter.sv
// Cycle counter bounding the result wait. Clear has priority over enable;
// tc is high while the count sits at TIMEOUT_CYCLES-1.
module timeout_counter #(
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
   input  logic clk,
   input  logic i_reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   // Count register: synchronous active-low reset, clear beats enable.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is always updated with <= so every register
      // samples pre-edge values, independent of block evaluation order.
      if (!i_reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + CNT_W'(1);
   end

   assign tc = (count == TC_VAL);

endmodule

// File: rtl/alu_cmd_master.sv
// Host-side initiator for the UART ALU link: flushes stale RX bytes, sends
// the A/B/OPCODE frame into the TX FIFO, then waits (bounded) for the result.
module alu_cmd_master
   import uart_alu_pkg::*;
#(
   parameter int BUS_SIZE       = 8,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic [BUS_SIZE-1:0] i_op_a,
   input  logic [BUS_SIZE-1:0] i_op_b,
   input  logic [BUS_SIZE-3:0] i_opcode,
   input  logic                i_tx_full,
   output logic                o_wr_uart,
   output logic [BUS_SIZE-1:0] o_w_data,
   input  logic                i_rx_empty,
   input  logic [BUS_SIZE-1:0] i_r_data,
   output logic                o_rd_uart,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_timeout,
   output logic [BUS_SIZE-1:0] o_result
);

   localparam int OP_W = BUS_SIZE - 2;

   state_t              state, next_state;
   logic [BUS_SIZE-1:0] op_a, op_b;
   logic [OP_W-1:0]     opcode;
   logic                load_ops;
   logic                take_result;
   logic                fire_timeout;
   logic                cnt_clear, cnt_en, cnt_tc;

   timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .i_reset (i_reset),
      .clear   (cnt_clear),
      .enable  (cnt_en),
      .tc      (cnt_tc)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!i_reset)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   // Next-state and FIFO strobe decode; strobes are suppressed while reset
   // is asserted so an abandoned frame never emits a write or pop.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      next_state   = state;
      o_wr_uart    = 1'b0;
      o_w_data     = '0;
      o_rd_uart    = 1'b0;
      load_ops     = 1'b0;
      take_result  = 1'b0;
      fire_timeout = 1'b0;
      cnt_clear    = 1'b1;
      cnt_en       = 1'b0;
      if (i_reset) begin
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  load_ops   = 1'b1;
                  next_state = ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (!i_rx_empty)
                  o_rd_uart = 1'b1;        // stale byte, discarded
               else
                  next_state = ST_SEND_A;
            end
            ST_SEND_A: begin
               if (!i_tx_full) begin
                  o_wr_uart  = 1'b1;
                  o_w_data   = op_a;
                  next_state = ST_SEND_B;
               end
            end
            ST_SEND_B: begin
               if (!i_tx_full) begin
                  o_wr_uart  = 1'b1;
                  o_w_data   = op_b;
                  next_state = ST_SEND_OP;
               end
            end
            ST_SEND_OP: begin
               if (!i_tx_full) begin
                  o_wr_uart  = 1'b1;
                  o_w_data   = BUS_SIZE'(opcode);   // zero-extended
                  next_state = ST_WAIT_RES;
               end
            end
            ST_WAIT_RES: begin
               cnt_clear = 1'b0;
               if (!i_rx_empty) begin
                  // A byte on the terminal-count cycle still completes normally.
                  o_rd_uart   = 1'b1;
                  take_result = 1'b1;
                  next_state  = ST_IDLE;
               end else begin
                  cnt_en = 1'b1;
                  if (cnt_tc) begin
                     fire_timeout = 1'b1;
                     next_state   = ST_IDLE;
                  end
               end
            end
            default: next_state = ST_IDLE;
         endcase
      end
   end

   // Operand latches, captured only when a start is accepted in IDLE.
   always_ff @(posedge clk) begin
      // NOTE: these are plain registers, not a memory array, so they take the
      // reset and the frame after reset never carries stale operands.
      if (!i_reset) begin
         op_a   <= '0;
         op_b   <= '0;
         opcode <= '0;
      end else if (load_ops) begin
         op_a   <= i_op_a;
         op_b   <= i_op_b;
         opcode <= i_opcode;
      end
   end

   // Completion status: one-cycle done/timeout pulses and the held result.
   always_ff @(posedge clk) begin
      if (!i_reset) begin
         o_done    <= 1'b0;
         o_timeout <= 1'b0;
         o_result  <= '0;
      end else begin
         o_done    <= take_result | fire_timeout;
         o_timeout <= fire_timeout;
         if (take_result)
            o_result <= i_r_data;
      end
   end

   assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_master.sv
// Directed bench for alu_cmd_master with a small RX FIFO model and a TX
// write logger; all expected values are hand-computed constants.
module tb_alu_cmd_master;
   import uart_alu_pkg::*;

   logic       clk = 1'b0;
   logic       i_reset = 1'b0;
   logic       i_start = 1'b0;
   logic [7:0] i_op_a = '0, i_op_b = '0;
   logic [5:0] i_opcode = '0;
   logic       i_tx_full = 1'b0;
   logic       o_wr_uart, o_rd_uart, o_busy, o_done, o_timeout;
   logic [7:0] o_w_data, o_result, i_r_data;
   logic       i_rx_empty;

   int n_checks = 0;
   int n_fail   = 0;

   // RX FIFO model (filled by the stimulus, popped by the DUT).
   logic [7:0] rx_mem [0:15];
   int         rx_wr = 0;
   int         rx_rd = 0;
   int         pop_cnt = 0;
   // TX write log.
   logic [7:0] tx_log [0:63];
   int         tx_cnt = 0;

   assign i_rx_empty = (rx_wr == rx_rd);
   assign i_r_data   = rx_mem[rx_rd[3:0]];

   always #5 clk = ~clk;

   alu_cmd_master #(
      .BUS_SIZE       (8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk        (clk),
      .i_reset    (i_reset),
      .i_start    (i_start),
      .i_op_a     (i_op_a),
      .i_op_b     (i_op_b),
      .i_opcode   (i_opcode),
      .i_tx_full  (i_tx_full),
      .o_wr_uart  (o_wr_uart),
      .o_w_data   (o_w_data),
      .i_rx_empty (i_rx_empty),
      .i_r_data   (i_r_data),
      .o_rd_uart  (o_rd_uart),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_timeout  (o_timeout),
      .o_result   (o_result)
   );

   // FIFO-side monitor: log every write strobe, advance RX on every pop.
   always @(posedge clk) begin
      if (o_wr_uart && tx_cnt < 64) begin
         tx_log[tx_cnt] <= o_w_data;
         tx_cnt         <= tx_cnt + 1;
      end
      if (o_rd_uart) begin
         pop_cnt <= pop_cnt + 1;
         if (rx_rd < rx_wr) rx_rd <= rx_rd + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_rx(input logic [7:0] d);
      rx_mem[rx_wr[3:0]] = d;
      rx_wr = rx_wr + 1;
   endtask

   task automatic start_frame(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      i_op_a   = a;
      i_op_b   = b;
      i_opcode = op;
      i_start  = 1'b1;
      tick();
      i_start  = 1'b0;
   endtask

   int tb_base, pb_base;

   initial begin
      // Reset state
      repeat (3) tick();
      check("rst_busy",    o_busy,    0);
      check("rst_done",    o_done,    0);
      check("rst_timeout", o_timeout, 0);
      check("rst_result",  o_result,  0);
      check("rst_wr",      o_wr_uart, 0);
      i_reset = 1'b1;
      tick();

      // 1: basic frame 05,03,ADD -> result 08
      tb_base = tx_cnt; pb_base = pop_cnt;
      start_frame(8'h05, 8'h03, OP_ADD);
      check("t1_busy", o_busy, 1);
      tick();
      check("t1_wr_a",   o_wr_uart, 1);
      check("t1_data_a", o_w_data,  8'h05);
      tick();
      check("t1_data_b", o_w_data,  8'h03);
      tick();
      check("t1_data_op", o_w_data, 8'h20);
      tick();
      check("t1_nwr",  tx_cnt - tb_base, FRAME_LEN);
      check("t1_log0", tx_log[tb_base],     8'h05);
      check("t1_log1", tx_log[tb_base + 1], 8'h03);
      check("t1_log2", tx_log[tb_base + 2], 8'h20);
      check("t1_idle_wr", o_wr_uart, 0);
      push_rx(8'h08);
      #1;
      check("t1_rd", o_rd_uart, 1);
      tick();
      check("t1_done",    o_done,    1);
      check("t1_timeout", o_timeout, 0);
      check("t1_result",  o_result,  8'h08);
      check("t1_busy_lo", o_busy,    0);
      check("t1_pops",    pop_cnt - pb_base, 1);
      tick();
      check("t1_done_pulse", o_done,   0);
      check("t1_result_hold", o_result, 8'h08);

      // 2: TX full for 10 cycles during SEND_B
      tb_base = tx_cnt;
      start_frame(8'h11, 8'h22, OP_SUB);
      tick();
      tick();
      i_tx_full = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         check("t2_no_wr_full", o_wr_uart, 0);
         tick();
      end
      i_tx_full = 1'b0;
      tick();
      tick();
      check("t2_nwr",  tx_cnt - tb_base, 3);
      check("t2_log0", tx_log[tb_base],     8'h11);
      check("t2_log1", tx_log[tb_base + 1], 8'h22);
      check("t2_log2", tx_log[tb_base + 2], 8'h22);
      push_rx(8'h33);
      tick();
      check("t2_done",   o_done,   1);
      check("t2_result", o_result, 8'h33);
      tick();

      // 3: two stale bytes flushed before the frame
      push_rx(8'hAA);
      push_rx(8'hBB);
      tb_base = tx_cnt; pb_base = pop_cnt;
      start_frame(8'h40, 8'h04, OP_ADD);
      tick();
      tick();
      tick();
      check("t3_flush_pops", pop_cnt - pb_base, 2);
      check("t3_no_wr_yet",  tx_cnt - tb_base,  0);
      check("t3_wr_a",       o_wr_uart,         1);
      tick();
      tick();
      tick();
      push_rx(8'h44);
      tick();
      check("t3_done",   o_done,   1);
      check("t3_result", o_result, 8'h44);
      check("t3_pops",   pop_cnt - pb_base, 3);
      check("t3_nwr",    tx_cnt - tb_base,  3);
      tick();

      // 4: timeout, TIMEOUT_CYCLES=16
      start_frame(8'h01, 8'h01, OP_XOR);
      repeat (4) tick();
      repeat (15) tick();
      check("t4_done_early", o_done, 0);
      check("t4_busy_wait",  o_busy, 1);
      tick();
      check("t4_done",    o_done,    1);
      check("t4_timeout", o_timeout, 1);
      check("t4_result",  o_result,  8'h44);
      check("t4_busy",    o_busy,    0);
      tick();
      check("t4_done_pulse",    o_done,    0);
      check("t4_timeout_pulse", o_timeout, 0);
      check("t4_busy_after",    o_busy,    0);

      // 5: reset in SEND_B abandons the frame
      tb_base = tx_cnt;
      start_frame(8'h0A, 8'h0B, OP_OR);
      tick();
      tick();
      i_reset = 1'b0;
      #1;
      check("t5_wr_in_rst", o_wr_uart, 0);
      tick();
      check("t5_busy", o_busy, 0);
      tick();
      i_reset = 1'b1;
      tick();
      check("t5_nwr",      tx_cnt - tb_base, 1);
      check("t5_rst_result", o_result, 0);
      tb_base = tx_cnt;
      start_frame(8'h55, 8'h66, OP_AND);
      repeat (4) tick();
      push_rx(8'h77);
      tick();
      check("t5_result", o_result, 8'h77);
      check("t5_log0", tx_log[tb_base],     8'h55);
      check("t5_log1", tx_log[tb_base + 1], 8'h66);
      check("t5_log2", tx_log[tb_base + 2], 8'h24);
      tick();

      // 6: start while busy with new operands is ignored
      tb_base = tx_cnt;
      start_frame(8'h01, 8'h02, OP_OR);
      i_op_a   = 8'hFF;
      i_op_b   = 8'hFE;
      i_opcode = 6'h3F;
      i_start  = 1'b1;
      tick();
      i_start  = 1'b0;
      tick();
      tick();
      tick();
      check("t6_nwr",  tx_cnt - tb_base, 3);
      check("t6_log0", tx_log[tb_base],     8'h01);
      check("t6_log1", tx_log[tb_base + 1], 8'h02);
      check("t6_log2", tx_log[tb_base + 2], 8'h25);
      push_rx(8'h03);
      tick();
      check("t6_done",   o_done,   1);
      check("t6_result", o_result, 8'h03);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
